sdram_ctrl: RTL

SDRAM_CTRL -- requirements
Module: sdram_ctrl

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_refresh_timer.sv | 33 +++
 rtl/sdram_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings ({CSn,RASn,CASn,WEn}) and controller state type.
package sdram_pkg;

  typedef logic [3:0] SDRAMCMD;

  localparam SDRAMCMD INHIBIT   = 4'b1111;
  localparam SDRAMCMD NOP       = 4'b0111;
  localparam SDRAMCMD ACTIVE    = 4'b0011;
  localparam SDRAMCMD READ      = 4'b0101;
  localparam SDRAMCMD WRITE     = 4'b0100;
  localparam SDRAMCMD PRECHARGE = 4'b0010;
  localparam SDRAMCMD REFRESH   = 4'b0001;
  localparam SDRAMCMD LOADMODE  = 4'b0000;

  typedef enum logic [3:0] {
    S_RST, S_INIT, S_PRE, S_IREF1, S_IREF2, S_MRS,
    S_IDLE, S_ACT, S_RD, S_WR, S_REF, S_WAIT
  } state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic auto-refresh request: counts refCycles clocks, holds a single pending flag until serviced.
module sdram_refresh_timer #(
  parameter int refCycles = 781
)(
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic pending
);

  localparam int CW = $clog2(refCycles + 1);

  logic [CW-1:0] cnt;
  logic          pend_q;
  logic          expire;

  assign expire  = en && (cnt == '0);
  // Expiry is visible in its own cycle so a same-cycle request loses to the refresh.
  assign pending = pend_q | expire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= CW'(refCycles - 1);
      pend_q <= 1'b0;
    end else begin
      if (!en || expire) cnt <= CW'(refCycles - 1);
      else               cnt <= cnt - CW'(1);
      pend_q <= expire | (pend_q & ~clr);
    end
  end

endmodule

// File: rtl/sdram_ctrl.sv
// Single-word SDRAM controller: power-up init, auto-precharged reads/writes, periodic refresh.
module sdram_ctrl
  import sdram_pkg::*;
#(
  parameter int bankBits   = 2,
  parameter int rowBits    = 13,
  parameter int colBits    = 9,
  parameter int dataBits   = 16,
  parameter int casLat     = 2,
  parameter int tRCD       = 2,
  parameter int tRP        = 2,
  parameter int tRC        = 7,
  parameter int tMRD       = 2,
  parameter int refCycles  = 781,
  parameter int initCycles = 20000
)(
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [bankBits+rowBits+colBits-1:0] addr,
  input  logic                              r,
  input  logic                              w,
  input  logic [dataBits-1:0]               dw,
  output logic [dataBits-1:0]               dr,
  output logic                              drValid,
  output logic                              busy,
  output logic                              CLK,
  output logic                              CKE,
  output SDRAMCMD                           CMD,
  output logic [dataBits/8-1:0]             DQM,
  output logic [bankBits-1:0]               BA,
  output logic [rowBits-1:0]                A,
  inout  wire  [dataBits-1:0]               D
);

  localparam int CW      = $clog2(initCycles + tRC + tRP + casLat + 8);
  // Cycles from READ/WRITE until IDLE: tRC from ACTIVE and tRP after the data phase.
  localparam int RD_HOLD = (tRC - tRCD > casLat + tRP) ? tRC - tRCD : casLat + tRP;
  localparam int WR_HOLD = (tRC - tRCD > tRP) ? tRC - tRCD : tRP;

  state_t               state, state_n, ret, ret_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 is_wr, init_done, ref_pend, accept;
  logic [casLat-1:0]    rd_pipe;
  logic [bankBits-1:0]  bank_q;
  logic [rowBits-1:0]   row_q;
  logic [colBits-1:0]   col_q;
  logic [dataBits-1:0]  dw_q;
  SDRAMCMD              cmd;
  logic [rowBits-1:0]   a_cmd;
  logic [bankBits-1:0]  ba_cmd;

  sdram_refresh_timer #(.refCycles(refCycles)) u_refresh (
    .clk     (clk),
    .rstn    (rstn),
    .en      (init_done),
    .clr     (state == S_REF),
    .pending (ref_pend)
  );

  assign accept = (state == S_IDLE) && !ref_pend && (r || w);
  assign busy   = !((state == S_IDLE) && !ref_pend);
  assign CMD    = cmd;
  assign A      = a_cmd;
  assign BA     = ba_cmd;
  assign CKE    = (state != S_RST);
  assign DQM    = (state == S_RST) ? '1 : '0;
  assign CLK    = ~clk;
  assign D      = (state == S_WR) ? dw_q : 'z;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_RST;
      ret       <= S_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      init_done <= 1'b0;
      rd_pipe   <= '0;
      dr        <= '0;
      drValid   <= 1'b0;
    end else begin
      state   <= state_n;
      ret     <= ret_n;
      cnt     <= cnt_n;
      if (accept) is_wr <= w;
      if (state == S_IDLE) init_done <= 1'b1;
      // rd_pipe[k] is high k+1 cycles after READ; capture lands casLat+1 cycles after it.
      rd_pipe <= {rd_pipe[casLat-2:0], state == S_RD};
      drValid <= rd_pipe[casLat-1];
      if (rd_pipe[casLat-1]) dr <= D;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      {bank_q, row_q, col_q} <= addr;
      dw_q                   <= dw;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ret_n   = ret;
    cmd     = NOP;
    a_cmd   = '0;
    ba_cmd  = '0;
    case (state)
      S_RST:   begin cmd = INHIBIT; state_n = S_INIT; cnt_n = CW'(initCycles - 1); end
      S_INIT:  if (cnt == '0) state_n = S_PRE; else cnt_n = cnt - CW'(1);
      S_PRE:   begin
        cmd = PRECHARGE; a_cmd[10] = 1'b1;
        state_n = S_WAIT; cnt_n = CW'(tRP - 2); ret_n = S_IREF1;
      end
      S_IREF1: begin cmd = REFRESH; state_n = S_WAIT; cnt_n = CW'(tRC - 2); ret_n = S_IREF2; end
      S_IREF2: begin cmd = REFRESH; state_n = S_WAIT; cnt_n = CW'(tRC - 2); ret_n = S_MRS; end
      S_MRS:   begin
        cmd = LOADMODE; a_cmd[6:4] = 3'(casLat);
        state_n = S_WAIT; cnt_n = CW'(tMRD - 2); ret_n = S_IDLE;
      end
      S_IDLE:  if (ref_pend) state_n = S_REF; else if (r || w) state_n = S_ACT;
      S_ACT:   begin
        cmd = ACTIVE; ba_cmd = bank_q; a_cmd = row_q;
        state_n = S_WAIT; cnt_n = CW'(tRCD - 2); ret_n = is_wr ? S_WR : S_RD;
      end
      S_RD:    begin
        cmd = READ; ba_cmd = bank_q; a_cmd[colBits-1:0] = col_q; a_cmd[10] = 1'b1;
        state_n = S_WAIT; cnt_n = CW'(RD_HOLD - 2); ret_n = S_IDLE;
      end
      S_WR:    begin
        cmd = WRITE; ba_cmd = bank_q; a_cmd[colBits-1:0] = col_q; a_cmd[10] = 1'b1;
        state_n = S_WAIT; cnt_n = CW'(WR_HOLD - 2); ret_n = S_IDLE;
      end
      S_REF:   begin cmd = REFRESH; state_n = S_WAIT; cnt_n = CW'(tRC - 2); ret_n = S_IDLE; end
      S_WAIT:  if (cnt == '0) state_n = ret; else cnt_n = cnt - CW'(1);
      default: state_n = S_RST;
    endcase
  end

endmodule
